// File: rtl/nexys2_flash_cmd_sequencer.sv
// Turns one host flash command into Intel-style bus accesses on the memory controller's p1 port.
// Optional build macro FLASH_UNLOCK_EN prepends a block-unlock pair to PROGRAM and ERASE.
module nexys2_flash_cmd_sequencer #(
    parameter int                POLL_W     = 24,
    parameter logic [POLL_W-1:0] POLL_LIMIT = 24'hFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  cmd,
    input  logic        cmd_valid,
    input  logic [22:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic [7:0]  status,
    output logic        err_flash,
    output logic        err_timeout,
    output logic [22:0] mem_address,
    output logic [15:0] mem_to_mem,
    output logic        mem_req,
    output logic        mem_wren,
    input  logic [15:0] mem_from_mem,
    input  logic        mem_ready
);
    localparam logic [1:0] C_READ = 2'd0, C_PROG = 2'd1, C_ERASE = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;
    typedef enum logic [3:0] {K_READ, K_UNLK1, K_UNLK2, K_CMD1, K_CMD2,
                              K_POLLW, K_POLLR, K_CLR, K_RST} step_t;

    state_t            state_q, state_d;
    step_t             step_q, step_d, first_step;
    logic [1:0]        cmd_q, cmd_d;
    logic [22:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic [7:0]        status_q, status_d;
    logic              err_flash_q, err_flash_d, err_timeout_q, err_timeout_d;
    logic [POLL_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            step_q        <= K_READ;
            cmd_q         <= 2'd0;
            addr_q        <= 23'd0;
            wdata_q       <= 16'd0;
            rdata_q       <= 16'd0;
            status_q      <= 8'd0;
            err_flash_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            status_q      <= status_d;
            err_flash_q   <= err_flash_d;
            err_timeout_q <= err_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        first_step = (cmd == C_READ) ? K_READ : K_CMD1;
`ifdef FLASH_UNLOCK_EN
        if (cmd == C_PROG || cmd == C_ERASE) first_step = K_UNLK1;
`endif
    end

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        status_d      = status_q;
        err_flash_d   = err_flash_q;
        err_timeout_d = err_timeout_q;
        cnt_d         = cnt_q;
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                cmd_d         = cmd;
                addr_d        = cmd_addr;
                wdata_d       = cmd_wdata;
                err_flash_d   = 1'b0;
                err_timeout_d = 1'b0;
                cnt_d         = '0;
                step_d        = first_step;
                state_d       = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: if (mem_ready) begin
                if (step_q == K_READ) rdata_d = mem_from_mem;
                if (step_q == K_POLLR) begin
                    status_d = mem_from_mem[7:0];
                    cnt_d    = cnt_q + POLL_W'(1);
                    if (mem_from_mem[7])
                        err_flash_d = mem_from_mem[5] | mem_from_mem[4] |
                                      mem_from_mem[3] | mem_from_mem[1];
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                state_d = S_ISSUE;
                case (step_q)
                    K_UNLK1: step_d = K_UNLK2;
                    K_UNLK2: step_d = K_CMD1;
                    K_CMD1:  step_d = (cmd_q == C_PROG || cmd_q == C_ERASE) ? K_CMD2 : K_RST;
                    K_CMD2:  step_d = K_POLLW;
                    K_POLLW: step_d = K_POLLR;
                    K_POLLR: begin
                        // A failed operation leaves error bits latched in SR; clear them before read-array.
                        if (status_q[7]) step_d = err_flash_q ? K_CLR : K_RST;
                        else if (cnt_q == POLL_LIMIT) begin
                            err_timeout_d = 1'b1;
                            step_d        = K_RST;
                        end else step_d = K_POLLR;
                    end
                    K_CLR:   step_d = K_RST;
                    default: state_d = S_DONE;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE) && (state_q != S_DONE);
        done        = (state_q == S_DONE);
        mem_req     = (state_q == S_ISSUE);
        mem_wren    = 1'b0;
        mem_to_mem  = 16'h0000;
        if (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_NEXT) begin
            mem_wren = (step_q != K_READ) && (step_q != K_POLLR);
            case (step_q)
                K_UNLK1: mem_to_mem = 16'h0060;
                K_UNLK2: mem_to_mem = 16'h00D0;
                K_CMD1:  mem_to_mem = (cmd_q == C_PROG)  ? 16'h0040 :
                                      (cmd_q == C_ERASE) ? 16'h0020 : 16'h0050;
                K_CMD2:  mem_to_mem = (cmd_q == C_PROG) ? wdata_q : 16'h00D0;
                K_POLLW: mem_to_mem = 16'h0070;
                K_CLR:   mem_to_mem = 16'h0050;
                K_RST:   mem_to_mem = 16'h00FF;
                default: mem_to_mem = 16'h0000;
            endcase
        end
    end

    assign mem_address = addr_q;
    assign rdata       = rdata_q;
    assign status      = status_q;
    assign err_flash   = err_flash_q;
    assign err_timeout = err_timeout_q;
endmodule
